// File: rtl/trivium_pkg.sv
// trivium_pkg: shared constants, state codes and seed expansion for the
// three-register stream cipher (encryptor and decryptor).
package trivium_pkg;
   localparam int SEED_W = 8;
   localparam int LFSR_W = 64;
   localparam logic [LFSR_W-1:0] INIT_S1 = 64'h23A2B;
   localparam logic [LFSR_W-1:0] INIT_S2 = 64'h2A892;
   localparam logic [LFSR_W-1:0] INIT_S3 = 64'hF4511;
   localparam logic [SEED_W-1:0] SEED_RSV_LO = 8'h00;
   localparam logic [SEED_W-1:0] SEED_RSV_HI = 8'hFF;
   localparam logic [1:0] UNSEEDED = 2'd0;
   localparam logic [1:0] READY    = 2'd1;
   localparam logic [1:0] GEN      = 2'd2;
   localparam logic [1:0] OUT      = 2'd3;

   typedef struct packed {
      logic [LFSR_W-1:0] s1;
      logic [LFSR_W-1:0] s2;
      logic [LFSR_W-1:0] s3;
   } lfsr_set_t;

   function automatic logic seed_reserved(input logic [SEED_W-1:0] seed);
      return seed == SEED_RSV_LO || seed == SEED_RSV_HI;
   endfunction

   function automatic lfsr_set_t expand_seed(input logic [SEED_W-1:0] seed);
      lfsr_set_t r;
      r.s1 = {48'd0, seed, seed};
      r.s2 = {48'd0, seed, ~seed[3:0], seed[7:4]};
      r.s3 = {48'd0, seed, seed ^ 8'hA5};
      return r;
   endfunction
endpackage

// File: rtl/trivium_stream_decryptor_ks_core.sv
// trivium_ks_core: the three 64-bit feedback registers; one keystream bit per
// step, reloadable from an 8-bit seed. Shared with the encryptor.
module trivium_ks_core
   import trivium_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic [SEED_W-1:0] seed,
   input  logic              step,
   output logic              k
);
   logic [LFSR_W-1:0] s1, s2, s3;
   lfsr_set_t init;

   assign init = expand_seed(seed);
   assign k = s1[0] ^ s2[0] ^ s3[0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1 <= INIT_S1;
         s2 <= INIT_S2;
         s3 <= INIT_S3;
      end else if (load) begin
         s1 <= init.s1;
         s2 <= init.s2;
         s3 <= init.s3;
      end else if (step) begin
         s1 <= {s1[62:0], s2[0] ^ s3[1] ^ s1[5] ^ s2[7] ^ s3[13] ^ s1[31] ^ s2[47] ^ s3[60]};
         s2 <= {s2[62:0], s3[3] ^ s1[1] ^ s2[2] ^ s3[19] ^ s1[23]};
         s3 <= {s3[62:0], s1[5] ^ s2[2] ^ s3[4] ^ s1[17] ^ s2[29] ^ s3[63] ^ s1[10] ^ s2[40]};
      end
   end
endmodule

// File: rtl/trivium_stream_decryptor.sv
// trivium_stream_decryptor: byte-wide ready/valid decryptor, 8 keystream steps
// per byte. Define TRIVIUM_DEC_BYTECNT_EN to add the byte_cnt handshake counter.
module trivium_stream_decryptor
   import trivium_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic [SEED_W-1:0] seed,
   input  logic              seed_load,
   output logic              seed_err,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy
`ifdef TRIVIUM_DEC_BYTECNT_EN
   ,
   output logic [15:0]       byte_cnt
`endif
);
   logic [1:0] state;
   logic [2:0] cnt;
   logic [7:0] data;
   logic [6:0] ks;
   logic       prev_bit, k, seed_ok;

   assign seed_ok = seed_load && !seed_reserved(seed);
   assign busy = state == GEN || state == OUT;

   trivium_ks_core u_core (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (seed_ok),
      .seed  (seed),
      .step  (state == GEN && !seed_ok),
      .k     (k)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= UNSEEDED;
         cnt       <= 3'd0;
         data      <= 8'd0;
         ks        <= 7'd0;
         prev_bit  <= 1'b0;
         seed_err  <= 1'b0;
         in_ready  <= 1'b0;
         out_data  <= 8'd0;
         out_valid <= 1'b0;
      end else begin
         seed_err <= seed_load && !seed_ok;
         if (seed_ok) begin
            state     <= READY;
            cnt       <= 3'd0;
            prev_bit  <= 1'b0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
         end else begin
            case (state)
               READY: if (in_valid) begin
                  data     <= in_data;
                  cnt      <= 3'd0;
                  in_ready <= 1'b0;
                  state    <= GEN;
               end
               GEN: begin
                  // k0..k6 fill ks; k7 is held back as the next byte's MSB
                  ks  <= {ks[5:0], k};
                  cnt <= cnt + 3'd1;
                  if (cnt == 3'd7) begin
                     out_data  <= data ^ {prev_bit, ks};
                     prev_bit  <= k;
                     out_valid <= 1'b1;
                     state     <= OUT;
                  end
               end
               OUT: if (out_ready) begin
                  out_valid <= 1'b0;
                  in_ready  <= 1'b1;
                  state     <= READY;
               end
               default: ;
            endcase
         end
      end
   end

`ifdef TRIVIUM_DEC_BYTECNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) byte_cnt <= 16'd0;
      else if (seed_ok) byte_cnt <= 16'd0;
      else if (out_valid && out_ready) byte_cnt <= byte_cnt + 16'd1;
   end
`endif
endmodule

// File: doc/trivium_stream_decryptor.md
Name: trivium_stream_decryptor

Overview:
- Receive end of the team's three-register stream cipher. Recovers plaintext bytes from ciphertext produced by the byte encryptor, given the same 8-bit seed.
- Byte-oriented ready/valid on both sides. Generates exactly 8 keystream bits per accepted byte, so it is independent of sender pacing.
- Sits between the link deserializer and the plaintext consumer.

Parameters:
- SEED_W, 8, seed width; fixed by the sender's seeding rule.
- LFSR_W, 64, width of each of s1/s2/s3.

Ports:
- clk  in  1  clock
- rst_n  in  1  async active-low reset
- seed  in  8  seed value, sampled when seed_load=1
- seed_load  in  1  one-cycle strobe: (re)seed the generator
- seed_err  out  1  registered pulse: last seed_load used a reserved seed
- in_data  in  8  ciphertext byte
- in_valid  in  1  ciphertext byte present
- in_ready  out  1  decryptor can accept a byte
- out_data  out  8  plaintext byte
- out_valid  out  1  plaintext byte present
- out_ready  in  1  consumer accepts the plaintext byte
- busy  out  1  high in GEN or OUT

Behaviour:
- Reset and clock: rst_n is asynchronous, active-low; clock is clk.
- Reset values:
  - s1 = 64'h23A2B, s2 = 64'h2A892, s3 = 64'hF4511
  - all outputs 0; prev_bit = 0; state = UNSEEDED
- Reserved seeds: 8'h00 and 8'hFF.
  - seed_load with a reserved seed: seed_err=1 for one cycle; nothing else changes.
- Valid seed load, in any state:
  - s1 = {48'd0, seed, seed}
  - s2 = {48'd0, seed, ~seed[3:0], seed[7:4]}
  - s3 = {48'd0, seed, seed^8'hA5}
  - prev_bit = 0; out_valid = 0 (a pending byte is dropped); state -> READY.
  - Seeding has priority over every other event in the same cycle.
- Step, all updates simultaneous from old values:
  - k = s1[0]^s2[0]^s3[0]
  - s1 <= {s1[62:0], s2[0]^s3[1]^s1[5]^s2[7]^s3[13]^s1[31]^s2[47]^s3[60]}
  - s2 <= {s2[62:0], s3[3]^s1[1]^s2[2]^s3[19]^s1[23]}
  - s3 <= {s3[62:0], s1[5]^s2[2]^s3[4]^s1[17]^s2[29]^s3[63]^s1[10]^s2[40]}
- Keystream byte n (the sender's decided convention), MSB first:
  - {prev_bit, k0, k1, k2, k3, k4, k5, k6}, where k0..k7 are the 8 step bits for that byte.
  - After the byte, prev_bit <= k7.
  - plaintext = ciphertext ^ keystream byte.
- States:
  - UNSEEDED: in_ready=0; in_valid is ignored.
  - READY: in_ready=1. On in_valid, latch in_data (accept edge A) -> GEN with step counter = 0.
  - GEN: one step per cycle on edges A+1..A+8. At edge A+8 register out_data, set out_valid=1 -> OUT.
  - OUT: hold out_data/out_valid stable until out_ready=1 -> READY; in_ready rises the following cycle.
- Latency and throughput:
  - Latency: accept edge to out_valid = 8 cycles.
  - Max throughput: 1 byte per 10 cycles with out_ready tied high.
- in_ready is registered and low outside READY; no byte is accepted in GEN or OUT.
- Step counter is 3 bits and wraps 7->0 only on GEN exit.
- A seed_load during GEN aborts the byte; no output is produced for it.
- rst_n low mid-byte: immediate return to reset values; the partially processed byte is lost.

Optional Feature:
- Macro: TRIVIUM_DEC_BYTECNT_EN.
- Defined: adds output byte_cnt[15:0], incremented on each out_valid&&out_ready handshake.
  - Wraps at 16'hFFFF -> 0.
  - Cleared by reset and by a valid seed load.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package trivium_pkg:
  - INIT_S1/S2/S3 constants
  - reserved seed constants 8'h00 and 8'hFF
  - state enum: UNSEEDED, READY, GEN, OUT
  - LFSR_W
  - seed-expansion function shared with the encryptor
- Sub-module trivium_ks_core:
  - the three LFSRs with seed load and step enable
  - outputs the current k
  - reusable by the encryptor
- Top module: FSM, prev_bit, byte assembly, handshakes.

Test Plan:
- Reset, then in_valid=1 with in_data=8'h12 and no seed -> in_ready stays 0, out_valid stays 0 for 50 cycles.
- seed_load with seed=8'h00, then with 8'hFF -> seed_err pulses once each; state stays UNSEEDED.
- Seed 8'h3C; golden encryptor model encrypts 8'h55, 8'hAA, 8'h00, 8'hFF -> out_data returns exactly those bytes. Each out_valid comes 8 cycles after its accept edge.
- Seed 8'h3C with out_ready held 0 for 20 cycles -> out_data stable, in_ready 0. Release -> next byte accepted 1 cycle later and decrypts correctly (prev_bit carried across the stall).
- Reseed with 8'h3C mid-GEN after 2 bytes -> that byte is dropped. The next ciphertext byte must equal byte 0 of a fresh 8'h3C stream and decrypts correctly.
- With TRIVIUM_DEC_BYTECNT_EN: 5 handshakes -> byte_cnt=5; a valid seed load -> byte_cnt=0.
